// File: rtl/alsu_param_if.sv
// Request/result bundle between a request source (master) and the ALSU (slave).
interface alsu_param_if #(
  parameter int WIDTH     = 3,
  parameter int LED_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2:0]           opcode;
  logic                 cin;
  logic                 serial_in;
  logic                 red_op_A;
  logic                 red_op_B;
  logic                 bypass_A;
  logic                 bypass_B;
  logic                 direction;
  logic [2*WIDTH-1:0]   out;
  logic                 out_valid;
  logic                 err;
  logic [LED_WIDTH-1:0] leds;

  modport master (
    output in_valid, A, B, opcode, cin, serial_in, red_op_A, red_op_B,
           bypass_A, bypass_B, direction,
    input  in_ready, out, out_valid, err, leds
  );
  modport slave (
    input  in_valid, A, B, opcode, cin, serial_in, red_op_A, red_op_B,
           bypass_A, bypass_B, direction,
    output in_ready, out, out_valid, err, leds
  );
endinterface

// File: rtl/alsu_param.sv
// Parametrised ALSU: one request in flight, 1-cycle ALU ops, WIDTH-cycle shift-add
// multiply, and a bounded LED blink after an invalid operation.
module alsu_param #(
  parameter int    WIDTH            = 3,
  parameter string INPUT_PRIORITY   = "A",
  parameter string FULL_ADDER       = "ON",
  parameter int    LED_WIDTH        = 16,
  parameter int    LED_BLINK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alsu_param_if.slave bus
);
  localparam int   OW    = 2 * WIDTH;
  localparam int   CW    = $clog2(WIDTH + 1);
  localparam int   BW    = $clog2(LED_BLINK_CYCLES + 1);
  localparam logic PRI_B = (INPUT_PRIORITY == "B");
  localparam logic FA_ON = (FULL_ADDER == "ON");

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             cin;
    logic             sin;
    logic             red_a;
    logic             red_b;
    logic             byp_a;
    logic             byp_b;
    logic             dir;
  } req_t;

  req_t                 req;
  logic [1:0]           state;
  logic [OW-1:0]        out_q, mcand, acc, acc_nxt, exec_res;
  logic [WIDTH-1:0]     mplier, pri_opnd, red_opnd;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        blink;
  logic [LED_WIDTH-1:0] leds_q;
  logic                 ov_q, err_q, exec_inv, exec_mul, mul_done, blink_load, res_ok;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.err       = err_q;
  assign bus.leds      = leds_q;

  // Invalid check outranks bypass, bypass outranks the opcode (including MULT).
  always_comb begin
    pri_opnd = PRI_B ? req.b : req.a;
    red_opnd = (req.red_a && req.red_b) ? pri_opnd : (req.red_b ? req.b : req.a);
    exec_inv = (req.op[2:1] == 2'b11) || ((req.red_a || req.red_b) && req.op[2:1] != 2'b00);
    exec_mul = 1'b0;
    exec_res = out_q;
    if (req.byp_a && req.byp_b) exec_res = OW'(pri_opnd);
    else if (req.byp_a)         exec_res = OW'(req.a);
    else if (req.byp_b)         exec_res = OW'(req.b);
    else begin
      case (req.op)
        3'b000:  exec_res = (req.red_a || req.red_b) ? OW'(|red_opnd) : OW'(req.a | req.b);
        3'b001:  exec_res = (req.red_a || req.red_b) ? OW'(^red_opnd) : OW'(req.a ^ req.b);
        3'b010:  exec_res = OW'(req.a) + OW'(req.b) + OW'(FA_ON & req.cin);
        3'b011:  exec_mul = 1'b1;
        3'b100:  exec_res = req.dir ? {out_q[OW-2:0], req.sin} : {req.sin, out_q[OW-1:1]};
        3'b101:  exec_res = req.dir ? {out_q[OW-2:0], out_q[OW-1]} : {out_q[0], out_q[OW-1:1]};
        default: ;
      endcase
    end
    acc_nxt    = mplier[0] ? acc + mcand : acc;
    mul_done   = (state == MUL) && (cnt == CW'(1));
    blink_load = (state == EXEC) && exec_inv;
    res_ok     = ((state == EXEC) && !exec_inv && !exec_mul) || mul_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req    <= '0;
      out_q  <= '0;
      ov_q   <= 1'b0;
      err_q  <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      ov_q  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          req <= '{a: bus.A, b: bus.B, op: bus.opcode, cin: bus.cin, sin: bus.serial_in,
                   red_a: bus.red_op_A, red_b: bus.red_op_B, byp_a: bus.bypass_A,
                   byp_b: bus.bypass_B, dir: bus.direction};
          state <= EXEC;
        end
        EXEC: begin
          if (exec_inv) begin
            out_q <= '0;
            err_q <= 1'b1;
            ov_q  <= 1'b1;
            state <= IDLE;
          end else if (exec_mul) begin
            mcand  <= OW'(req.a);
            mplier <= req.b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            state  <= MUL;
          end else begin
            out_q <= exec_res;
            ov_q  <= 1'b1;
            state <= IDLE;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (mul_done) begin
            out_q <= acc_nxt;
            ov_q  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reload on a repeated error keeps the current LED phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink  <= '0;
      leds_q <= '0;
    end else if (blink_load) begin
      blink <= BW'(LED_BLINK_CYCLES);
    end else if (res_ok) begin
      blink  <= '0;
      leds_q <= '0;
    end else if (blink != '0) begin
      blink  <= blink - BW'(1);
      leds_q <= ~leds_q;
    end else begin
      leds_q <= '0;
    end
  end
endmodule

// File: tb/tb_alsu_param.sv
// Directed bench: dut0 (FULL_ADDER ON, priority A, 4 blinks) and dut1 (OFF, B, 8 blinks)
// receive identical requests.
module tb_alsu_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alsu_param_if #(.WIDTH(4), .LED_WIDTH(16)) i0 ();
  alsu_param_if #(.WIDTH(4), .LED_WIDTH(16)) i1 ();

  alsu_param #(.WIDTH(4), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"),
               .LED_WIDTH(16), .LED_BLINK_CYCLES(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  alsu_param #(.WIDTH(4), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"),
               .LED_WIDTH(16), .LED_BLINK_CYCLES(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic sin, input logic ra, input logic rb,
                         input logic ba, input logic bb, input logic dir);
    i0.opcode = op;  i1.opcode = op;
    i0.A = a;        i1.A = a;
    i0.B = b;        i1.B = b;
    i0.cin = cin;    i1.cin = cin;
    i0.serial_in = sin; i1.serial_in = sin;
    i0.red_op_A = ra;   i1.red_op_A = ra;
    i0.red_op_B = rb;   i1.red_op_B = rb;
    i0.bypass_A = ba;   i1.bypass_A = ba;
    i0.bypass_B = bb;   i1.bypass_B = bb;
    i0.direction = dir; i1.direction = dir;
  endtask

  task automatic drive_valid(input logic v);
    i0.in_valid = v;
    i1.in_valid = v;
  endtask

  // Accept one request, then wait (bounded) for dut0's result strobe.
  task automatic run_op(output int lat);
    drive_valid(1'b1);
    tick();
    drive_valid(1'b0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!i0.out_valid && lat < 20);
  endtask

  int   lat;
  logic ov_seen;
  logic [15:0] lseq [5];

  initial begin
    lseq = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    drive_valid(1'b0);
    set_req(3'b000, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("rst_out", i0.out, 8'h00);
    chk("rst_ov", i0.out_valid, 0);
    chk("rst_err", i0.err, 0);
    chk("rst_leds", i0.leds, 16'h0000);
    chk("rst_ready", i0.in_ready, 1);
    rst_n = 1'b1;
    tick();

    // reset during multiply
    set_req(3'b011, 4'hD, 4'hB, 0, 0, 0, 0, 0, 0, 0);
    drive_valid(1'b1);
    tick();
    drive_valid(1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    ov_seen = 1'b0;
    repeat (2) begin tick(); ov_seen |= i0.out_valid | i1.out_valid; end
    rst_n = 1'b1;
    repeat (6) begin tick(); ov_seen |= i0.out_valid | i1.out_valid; end
    chk("rstmul_ov", ov_seen, 0);
    chk("rstmul_out", i0.out, 8'h00);
    chk("rstmul_leds", i0.leds, 16'h0000);
    chk("rstmul_ready", i0.in_ready, 1);

    // ADD with and without carry-in
    set_req(3'b010, 4'hF, 4'h1, 1, 0, 0, 0, 0, 0, 0);
    drive_valid(1'b1);
    tick();
    drive_valid(1'b0);
    chk("add_ov_t0", i0.out_valid, 0);
    tick();
    chk("add_ov_t1", i0.out_valid, 1);
    chk("add_on", i0.out, 8'h11);
    chk("add_off", i1.out, 8'h10);
    chk("add_err", i0.err, 0);
    tick();
    chk("add_ov_t2", i0.out_valid, 0);
    chk("add_hold", i0.out, 8'h11);

    // MULT with in_valid held high throughout
    set_req(3'b011, 4'hD, 4'hB, 0, 0, 0, 0, 0, 0, 0);
    drive_valid(1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("mul_busy%0d", k), i0.in_ready, 0);
      chk($sformatf("mul_noov%0d", k), i0.out_valid, 0);
      tick();
    end
    drive_valid(1'b0);
    chk("mul_ov", i0.out_valid, 1);
    chk("mul_out0", i0.out, 8'h8F);
    chk("mul_out1", i1.out, 8'h8F);
    chk("mul_ready", i0.in_ready, 1);
    tick();
    chk("mul_ov_after", i0.out_valid, 0);
    chk("mul_ready_after", i0.in_ready, 1);

    // OR reduction, both flags
    set_req(3'b000, 4'h0, 4'h8, 0, 0, 1, 1, 0, 0, 0);
    run_op(lat);
    chk("red_lat", lat, 1);
    chk("red_priA", i0.out, 8'h00);
    chk("red_priB", i1.out, 8'h01);
    chk("red_err", i0.err, 0);

    // bypass, both flags
    set_req(3'b010, 4'h5, 4'hA, 0, 0, 0, 0, 1, 1, 0);
    run_op(lat);
    chk("byp_lat", lat, 1);
    chk("byp_priA", i0.out, 8'h05);
    chk("byp_priB", i1.out, 8'h0A);

    // invalid opcode and blink sequence
    set_req(3'b111, 4'h5, 4'h3, 0, 0, 0, 0, 0, 0, 0);
    run_op(lat);
    chk("inv_lat", lat, 1);
    chk("inv_err", i0.err, 1);
    chk("inv_out", i0.out, 8'h00);
    chk("inv_leds0", i0.leds, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("blink%0d", k), i0.leds, lseq[k]);
      chk($sformatf("blink_err%0d", k), i0.err, 0);
    end

    // reduction with a non-logic opcode is invalid
    set_req(3'b010, 4'h5, 4'h3, 0, 0, 1, 0, 0, 0, 0);
    run_op(lat);
    chk("redadd_err", i1.err, 1);
    chk("redadd_out", i1.out, 8'h00);

    // ADD during blink clears leds
    set_req(3'b010, 4'h1, 4'h2, 0, 0, 0, 0, 0, 0, 0);
    drive_valid(1'b1);
    tick();
    drive_valid(1'b0);
    chk("clr_blink0", i0.leds, 16'hFFFF);
    chk("clr_blink1", i1.leds, 16'hFFFF);
    tick();
    chk("clr_ov", i0.out_valid, 1);
    chk("clr_out", i0.out, 8'h03);
    chk("clr_leds0", i0.leds, 16'h0000);
    chk("clr_leds1", i1.leds, 16'h0000);
    tick();
    chk("clr_stay1", i1.leds, 16'h0000);

    // shift / rotate
    set_req(3'b000, 4'h3, 4'h0, 0, 0, 0, 0, 1, 0, 0);
    run_op(lat);
    set_req(3'b101, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    run_op(lat);
    chk("rotr_03", i0.out, 8'h81);
    set_req(3'b100, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1);
    run_op(lat);
    chk("shl_81", i0.out, 8'h02);
    set_req(3'b000, 4'h3, 4'h0, 0, 0, 0, 0, 1, 0, 0);
    run_op(lat);
    set_req(3'b101, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    run_op(lat);
    run_op(lat);
    chk("rotr_81", i0.out, 8'hC0);
    set_req(3'b100, 4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0);
    run_op(lat);
    chk("shr_c0", i0.out, 8'hE0);
    set_req(3'b101, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1);
    run_op(lat);
    chk("rotl_e0", i0.out, 8'hC1);
    chk("rotl_lat", lat, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
